// File: rtl/epl_row_decode_seq.sv
// Sequenced row decoder for the EPLFFRAM array: latches a row request and drives
// its wordline(s) through a timed SETUP / ACTIVE / RECOVER pulse.
module epl_row_decode_seq #(
  parameter int ADDR_W    = 3,
  parameter int NROWS     = 8,
  parameter int SETUP_CYC = 1,
  parameter int WL_CYC    = 4,
  parameter int RECOV_CYC = 2
) (
  input  logic              pClk_i,
  input  logic              pRst_n_i,
  input  logic              pReq_i,
  input  logic [ADDR_W-1:0] pAr_i,
  input  logic              pAll_i,
  input  logic              pAbort_i,
  output logic              pRdy_o,
  output logic [NROWS-1:0]  pArx_o,
  output logic              pWlEn_o,
  output logic              pDone_o,
  output logic              pErr_o
);

  // state   | meaning
  // IDLE    | ready for a request; first IDLE cycle after a sequence flags done
  // SETUP   | address latched, wordlines still low (SETUP_CYC cycles)
  // ACTIVE  | selected wordline(s) driven (WL_CYC cycles)
  // RECOVER | wordlines low, recovery time before next access (RECOV_CYC cycles)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam int CNT_MAX_SW = (SETUP_CYC > WL_CYC) ? SETUP_CYC : WL_CYC;
  localparam int CNT_MAX    = (CNT_MAX_SW > RECOV_CYC) ? CNT_MAX_SW : RECOV_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // Down-counters load N-1 on state entry and the state ends on terminal count 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] WL_LD    = CNT_W'((WL_CYC > 0) ? WL_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'((RECOV_CYC > 0) ? RECOV_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [ADDR_W:0] NROWS_LIM = (ADDR_W + 1)'(NROWS);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              all_q, all_d;
  logic [NROWS-1:0]  arx_q, arx_d;
  logic              wl_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              addr_legal;
  logic              end_pulse;

  function automatic logic [NROWS-1:0] decode_rows(input logic [ADDR_W-1:0] addr,
                                                   input logic bulk);
    logic [NROWS-1:0] wl;
    for (int i = 0; i < NROWS; i++) begin
      wl[i] = bulk | ({1'b0, addr} == (ADDR_W + 1)'(i));
    end
    return wl;
  endfunction

  // Full-width compare so addresses between NROWS and 2**ADDR_W-1 are caught.
  assign addr_legal = ({1'b0, pAr_i} < NROWS_LIM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    all_d     = all_q;
    arx_d     = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    end_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pReq_i) begin
          if (pAll_i || addr_legal) begin
            row_d = pAr_i;
            all_d = pAll_i;
            if (SETUP_CYC > 0) begin
              state_d = ST_SETUP;
              cnt_d   = SETUP_LD;
            end else begin
              state_d = ST_ACTIVE;
              cnt_d   = WL_LD;
              arx_d   = decode_rows(pAr_i, pAll_i);
            end
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (pAbort_i) begin
          end_pulse = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = WL_LD;
          arx_d   = decode_rows(row_q, all_q);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_ACTIVE: begin
        // Abort on the expiry edge lands in the same place as normal expiry.
        if (pAbort_i || (cnt_q == '0)) begin
          end_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          arx_d = arx_q;
        end
      end

      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (end_pulse) begin
      arx_d = '0;
      if (RECOV_CYC > 0) begin
        state_d = ST_RECOVER;
        cnt_d   = RECOV_LD;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge pClk_i or negedge pRst_n_i) begin
    if (!pRst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      all_q   <= 1'b0;
      arx_q   <= '0;
      wl_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      all_q   <= all_d;
      arx_q   <= arx_d;
      wl_q    <= |arx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pRdy_o  = (state_q == ST_IDLE);
  assign pArx_o  = arx_q;
  assign pWlEn_o = wl_q;
  assign pDone_o = done_q;
  assign pErr_o  = err_q;

endmodule

// File: tb/tb_epl_row_decode_seq.sv
// Scoreboard bench for epl_row_decode_seq: three instances (default, NROWS=6,
// NROWS=6 without SETUP/RECOVER) share stimulus; one is observed per scenario.
module tb_epl_row_decode_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [2:0] ar = 3'd0;
  logic       all = 1'b0;
  logic       abort = 1'b0;

  logic       rdy_a, wl_a, done_a, err_a;
  logic [7:0] arx_a;
  logic       rdy_b, wl_b, done_b, err_b;
  logic [5:0] arx_b;
  logic       rdy_c, wl_c, done_c, err_c;
  logic [5:0] arx_c;

  typedef struct packed {
    logic [7:0] arx;
    logic       wl;
    logic       done;
    logic       err;
    logic       rdy;
  } ent_t;

  ent_t exp_q[$];
  ent_t act_q[$];
  int   sel = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  epl_row_decode_seq u_dut_a (
    .pClk_i(clk), .pRst_n_i(rst_n), .pReq_i(req), .pAr_i(ar), .pAll_i(all),
    .pAbort_i(abort), .pRdy_o(rdy_a), .pArx_o(arx_a), .pWlEn_o(wl_a),
    .pDone_o(done_a), .pErr_o(err_a)
  );

  epl_row_decode_seq #(.NROWS(6)) u_dut_b (
    .pClk_i(clk), .pRst_n_i(rst_n), .pReq_i(req), .pAr_i(ar), .pAll_i(all),
    .pAbort_i(abort), .pRdy_o(rdy_b), .pArx_o(arx_b), .pWlEn_o(wl_b),
    .pDone_o(done_b), .pErr_o(err_b)
  );

  epl_row_decode_seq #(.NROWS(6), .SETUP_CYC(0), .RECOV_CYC(0)) u_dut_c (
    .pClk_i(clk), .pRst_n_i(rst_n), .pReq_i(req), .pAr_i(ar), .pAll_i(all),
    .pAbort_i(abort), .pRdy_o(rdy_c), .pArx_o(arx_c), .pWlEn_o(wl_c),
    .pDone_o(done_c), .pErr_o(err_c)
  );

  function automatic ent_t mk(logic [7:0] a, logic w, logic d, logic e, logic r);
    ent_t x;
    x.arx = a; x.wl = w; x.done = d; x.err = e; x.rdy = r;
    return x;
  endfunction

  function automatic ent_t snap();
    ent_t x;
    case (sel)
      1:       x = mk({2'b00, arx_b}, wl_b, done_b, err_b, rdy_b);
      2:       x = mk({2'b00, arx_c}, wl_c, done_c, err_c, rdy_c);
      default: x = mk(arx_a, wl_a, done_a, err_a, rdy_a);
    endcase
    return x;
  endfunction

  // Expected per-cycle outputs from the acceptance edge onward.
  function automatic void push_seq(int nrows, int addr, bit bulk, int s, int w, int r);
    logic [7:0] pat;
    pat = bulk ? 8'((1 << nrows) - 1) : 8'(1 << addr);
    for (int i = 0; i < s; i++) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < w; i++) exp_q.push_back(mk(pat, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < r; i++) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
  endfunction

  function automatic void push_idle(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
  endfunction

  task automatic capture(int n);
    repeat (n) begin
      @(negedge clk);
      act_q.push_back(snap());
    end
  endtask

  task automatic do_reset();
    req = 1'b0; abort = 1'b0; all = 1'b0; ar = 3'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic accept(int a, bit b);
    req = 1'b1; ar = 3'(a); all = b;
    @(posedge clk);
    #1 req = 1'b0; ar = 3'(a + 3); all = ~b;
  endtask

  task automatic test_reset();
    ent_t a;
    rst_n = 1'b0; req = 1'b1;
    #12;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      a = snap();
      n_tests++;
      if (a !== mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %p, exp arx=0 wl=0 done=0 err=0 rdy=1", d, a);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_single();
    ent_t e, a;
    do_reset(); sel = 0;
    push_seq(8, 5, 1'b0, 1, 4, 2);
    push_idle(2);
    accept(5, 1'b0);
    capture(10);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); n_tests++;
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      if (a !== e) begin n_fail++; $display("FAIL single cyc%0d: got %p exp %p", k, a, e); end
    end
  endtask

  task automatic test_bulk();
    ent_t e, a;
    do_reset(); sel = 0;
    push_seq(8, 2, 1'b1, 1, 4, 2);
    accept(2, 1'b1);
    capture(8);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); n_tests++;
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      if (a !== e) begin n_fail++; $display("FAIL bulk cyc%0d: got %p exp %p", k, a, e); end
    end
  endtask

  task automatic test_back_to_back();
    ent_t e, a;
    do_reset(); sel = 0;
    push_seq(8, 0, 1'b0, 1, 4, 2);
    push_seq(8, 7, 1'b0, 1, 4, 2);
    req = 1'b1; ar = 3'd0; all = 1'b0;
    @(posedge clk);
    #1 ar = 3'd7;
    capture(9);
    req = 1'b0;
    capture(7);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); n_tests++;
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      if (a !== e) begin n_fail++; $display("FAIL b2b cyc%0d: got %p exp %p", k, a, e); end
    end
  endtask

  task automatic test_abort();
    ent_t e, a;
    do_reset(); sel = 0;
    // abort on 2nd ACTIVE cycle, held into RECOVER where it must be ignored
    push_seq(8, 4, 1'b0, 1, 2, 2);
    accept(4, 1'b0);
    capture(3);
    abort = 1'b1;
    capture(2);
    abort = 1'b0;
    capture(1);
    // abort during SETUP
    push_seq(8, 1, 1'b0, 1, 0, 2);
    accept(1, 1'b0);
    capture(1);
    abort = 1'b1;
    capture(1);
    abort = 1'b0;
    capture(2);
    // abort on the ACTIVE expiry edge
    push_seq(8, 6, 1'b0, 1, 4, 2);
    accept(6, 1'b0);
    capture(5);
    abort = 1'b1;
    capture(1);
    abort = 1'b0;
    capture(2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); n_tests++;
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      if (a !== e) begin n_fail++; $display("FAIL abort cyc%0d: got %p exp %p", k, a, e); end
    end
  endtask

  task automatic test_range();
    ent_t e, a;
    do_reset(); sel = 1;
    exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1));
    push_idle(1);
    req = 1'b1; ar = 3'd6; all = 1'b0;
    @(posedge clk);
    #1 ar = 3'd7;
    capture(2);
    req = 1'b0;
    capture(1);
    push_seq(6, 5, 1'b0, 1, 4, 2);
    accept(5, 1'b0);
    capture(8);
    push_seq(6, 7, 1'b1, 1, 4, 2);
    accept(7, 1'b1);
    capture(8);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); n_tests++;
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      if (a !== e) begin n_fail++; $display("FAIL range cyc%0d: got %p exp %p", k, a, e); end
    end
  endtask

  task automatic test_no_setup_recov();
    ent_t e, a;
    do_reset(); sel = 2;
    push_seq(6, 3, 1'b0, 0, 4, 0);
    push_idle(1);
    accept(3, 1'b0);
    capture(6);
    push_seq(6, 2, 1'b0, 0, 2, 0);
    push_idle(1);
    accept(2, 1'b0);
    capture(2);
    abort = 1'b1;
    capture(1);
    abort = 1'b0;
    capture(1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); n_tests++;
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      if (a !== e) begin n_fail++; $display("FAIL corner cyc%0d: got %p exp %p", k, a, e); end
    end
  endtask

  task automatic test_reset_mid();
    ent_t e, a;
    do_reset(); sel = 0;
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h40, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h40, 1'b1, 1'b0, 1'b0, 1'b0));
    accept(6, 1'b0);
    capture(3);
    #2 rst_n = 1'b0;
    #1 a = snap();
    n_tests++;
    if (a !== mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL rst_mid immediate: got %p, exp arx=0 wl=0 done=0 err=0 rdy=1", a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    capture(3);
    push_seq(8, 1, 1'b0, 1, 4, 2);
    accept(1, 1'b0);
    capture(8);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); n_tests++;
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      if (a !== e) begin n_fail++; $display("FAIL rst_mid cyc%0d: got %p exp %p", k, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bulk();
    test_back_to_back();
    test_abort();
    test_range();
    test_no_setup_recov();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no end of run, exp finish within 20000 cycles");
    $fatal(1);
  end

endmodule
